// File: rtl/sha256_ctrl_pkg.sv
// Shared constants for the SHA-256 sequencing controller: state encoding,
// round count and the initial hash value used by the digest accumulator.
package sha256_ctrl_pkg;

  localparam int NUM_ROUNDS_DEFAULT = 64;
  localparam logic [6:0] ITER_DONE = 7'd64;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_ROUND  = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_round_counter.sv
// Round index counter: synchronous clear, enable, saturates at NUM_ROUNDS and
// flags the final compression round (NUM_ROUNDS-1).
module sha256_round_counter #(
  parameter int NUM_ROUNDS = 64,
  parameter int CNT_W      = 7
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last_round
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(NUM_ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_ROUNDS);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt        = r_cnt;
  assign o_last_round = (r_cnt == CNT_TERM);

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block sequencing controller (IDLE/LOAD/ROUND/UPDATE/DONE).
// Optional synchronous abort input is compiled in with SHA_CTRL_ABORT_EN.
module sha256_round_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
  parameter int CNT_W      = 7,
  parameter int BLK_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SHA_CTRL_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 blk_valid,
  input  logic                 blk_first,
  input  logic                 blk_last,
  output logic                 blk_ready,
  output logic                 ws_load,
  output logic                 wv_load,
  output logic                 wv_init_sel,
  output logic                 h_init,
  output logic                 round_en,
  output logic [CNT_W-1:0]     counter_iteration,
  output logic                 h_update,
  output logic                 dig_valid,
  input  logic                 dig_ready,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_count
);

  logic [2:0]           r_state;
  logic                 r_open;
  logic                 r_first;
  logic                 r_last;
  logic [BLK_CNT_W-1:0] r_blk_count;

  logic [2:0]           w_state_nxt;
  logic                 w_abort;
  logic                 w_accept;
  logic                 w_new_msg;
  logic                 w_last_round;

`ifdef SHA_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept  = (r_state == ST_IDLE) && blk_valid;
  // A block without an open message starts one implicitly, so H must be seeded.
  assign w_new_msg = blk_first || !r_open;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (blk_valid)    w_state_nxt = ST_LOAD;
      ST_LOAD:                     w_state_nxt = ST_ROUND;
      ST_ROUND:  if (w_last_round) w_state_nxt = ST_UPDATE;
      ST_UPDATE:                   w_state_nxt = r_last ? ST_DONE : ST_IDLE;
      ST_DONE:   if (dig_ready)    w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_open      <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_blk_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_abort) begin
        r_open      <= 1'b0;
        r_blk_count <= '0;
      end else begin
        if (w_accept) begin
          r_first <= w_new_msg;
          r_last  <= blk_last;
          r_open  <= 1'b1;
          if (w_new_msg) r_blk_count <= '0;
        end
        if ((r_state == ST_UPDATE) && (r_blk_count != '1)) begin
          r_blk_count <= r_blk_count + 1'b1;
        end
        if ((r_state == ST_DONE) && dig_ready) r_open <= 1'b0;
      end
    end
  end

  // Counter returns to zero whenever the controller heads back to IDLE.
  sha256_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .CNT_W      (CNT_W)
  ) u_round_counter (
    .clk          (clk),
    .i_rst_n      (rst),
    .i_clr        (w_state_nxt == ST_IDLE),
    .i_en         (r_state == ST_ROUND),
    .o_cnt        (counter_iteration),
    .o_last_round (w_last_round)
  );

  assign blk_ready   = (r_state == ST_IDLE);
  assign ws_load     = (r_state == ST_LOAD);
  assign wv_load     = (r_state == ST_LOAD);
  assign wv_init_sel = (r_state == ST_LOAD) && r_first;
  assign h_init      = (r_state == ST_LOAD) && r_first;
  assign round_en    = (r_state == ST_ROUND);
  assign h_update    = (r_state == ST_UPDATE) && !w_abort;
  assign dig_valid   = (r_state == ST_DONE);
  assign busy        = (r_state != ST_IDLE);
  assign blk_count   = r_blk_count;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: block-sequence table, corner
// sequences and a randomized run against a cycle-age reference model.
module tb_sha256_round_ctrl;

  logic        clk = 1'b0;
  logic        rst, blk_valid, blk_first, blk_last, dig_ready, abort;
  logic        blk_ready, ws_load, wv_load, wv_init_sel, h_init, round_en;
  logic        h_update, dig_valid, busy;
  logic [6:0]  counter_iteration;
  logic [15:0] blk_count;

  always #5 clk = ~clk;

  sha256_round_ctrl dut (
    .clk               (clk),
    .rst               (rst),
`ifdef SHA_CTRL_ABORT_EN
    .abort             (abort),
`endif
    .blk_valid         (blk_valid),
    .blk_first         (blk_first),
    .blk_last          (blk_last),
    .blk_ready         (blk_ready),
    .ws_load           (ws_load),
    .wv_load           (wv_load),
    .wv_init_sel       (wv_init_sel),
    .h_init            (h_init),
    .round_en          (round_en),
    .counter_iteration (counter_iteration),
    .h_update          (h_update),
    .dig_valid         (dig_valid),
    .dig_ready         (dig_ready),
    .busy              (busy),
    .blk_count         (blk_count)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: m_age counts cycles since the accept (0 = load cycle,
  // 1..64 = rounds, 65 = chaining update); -1 means no block in flight.
  int m_age = -1;
  bit m_done, m_open, m_first, m_last;
  int m_cnt;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;

  function automatic logic [31:0] dut_vec();
    return {blk_ready, ws_load, wv_load, wv_init_sel, h_init, round_en,
            h_update, dig_valid, busy, counter_iteration, blk_count};
  endfunction

  function automatic logic [31:0] model_vec();
    bit rdy, ws, wv, sel, hi, ren, hu, dv, bz;
    int ci;
    {rdy, ws, wv, sel, hi, ren, hu, dv, bz} = '0;
    ci = 0;
    if (m_done) begin
      dv = 1; bz = 1; ci = 64;
    end else if (m_age < 0) begin
      rdy = 1;
    end else begin
      bz = 1;
      if (m_age == 0) begin
        ws = 1; wv = 1; sel = m_first; hi = m_first;
      end else if (m_age <= 64) begin
        ren = 1; ci = m_age - 1;
      end else begin
        hu = !abort; ci = 64;
      end
    end
    return {rdy, ws, wv, sel, hi, ren, hu, dv, bz, 7'(ci), 16'(m_cnt)};
  endfunction

  task automatic model_step();
    if (!rst) begin
      m_age = -1; m_done = 0; m_open = 0; m_first = 0; m_last = 0; m_cnt = 0;
    end else if (abort) begin
      m_age = -1; m_done = 0; m_open = 0; m_cnt = 0;
    end else if (m_done) begin
      if (dig_ready) begin m_done = 0; m_open = 0; end
    end else if (m_age < 0) begin
      if (blk_valid) begin
        m_first = blk_first || !m_open;
        if (m_first) m_cnt = 0;
        m_last = blk_last;
        m_open = 1;
        m_age  = 0;
      end
    end else if (m_age < 65) begin
      m_age++;
    end else begin
      if (m_cnt < 65535) m_cnt++;
      m_age  = -1;
      m_done = m_last;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    #1;
    if (chk_en) cmp("model", dut_vec(), model_vec());
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    bit first;
    bit last;
    bit exp_init;
    int exp_cnt;
    bit exp_dig;
    int dig_wait;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int hu_n, hu_at;
    bit found, seen;

    tbl[0] = '{1, 1, 1, 1, 1, 0};   // single-block message, same-cycle dig_ready
    tbl[1] = '{1, 0, 1, 1, 0, 0};   // first block of two
    tbl[2] = '{0, 1, 0, 2, 1, 10};  // second block, digest held 10 cycles
    tbl[3] = '{0, 0, 1, 1, 0, 0};   // no open message: starts one implicitly
    tbl[4] = '{1, 0, 1, 1, 0, 0};   // blk_first abandons the open message
    tbl[5] = '{0, 0, 0, 2, 0, 0};
    tbl[6] = '{1, 1, 1, 1, 1, 0};   // abandon again with a single-block message

    {blk_valid, blk_first, blk_last, dig_ready, abort} = '0;
    rst = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk_en = 1'b1;
    #1 cmp("reset_state", dut_vec(), RESET_VEC);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      blk_valid = 1; blk_first = tbl[i].first; blk_last = tbl[i].last;
      tick();
      {blk_valid, blk_first, blk_last} = '0;
      hu_n = 0; hu_at = -1;
      for (int k = 1; k <= 66; k++) begin
        if (k == 1) begin
          cmp("h_init", 32'(h_init), 32'(tbl[i].exp_init));
          cmp("wv_init_sel", 32'(wv_init_sel), 32'(tbl[i].exp_init));
        end
        if (h_update) begin
          hu_n++; hu_at = k;
          cmp("update_iter", 32'(counter_iteration), 32'd64);
        end
        tick();
      end
      cmp("h_update_count", 32'(hu_n), 32'd1);
      cmp("h_update_at", 32'(hu_at), 32'd66);
      cmp("blk_count", 32'(blk_count), 32'(tbl[i].exp_cnt));
      cmp("dig_valid", 32'(dig_valid), 32'(tbl[i].exp_dig));
      if (tbl[i].exp_dig) begin
        for (int w = 0; w < tbl[i].dig_wait; w++) begin
          cmp("hold_dig_valid", 32'(dig_valid), 32'd1);
          cmp("hold_blk_ready", 32'(blk_ready), 32'd0);
          cmp("hold_h_update", 32'(h_update), 32'd0);
          tick();
        end
        dig_ready = 1;
        tick();
        dig_ready = 0;
        cmp("dig_drop", 32'(dig_valid), 32'd0);
        cmp("ready_back", 32'(blk_ready), 32'd1);
      end
    end

    // Reset in the middle of the rounds.
    blk_valid = 1; blk_first = 1; blk_last = 1;
    tick();
    {blk_valid, blk_first, blk_last} = '0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (round_en && counter_iteration == 7'd30) begin found = 1; break; end
      tick();
    end
    cmp("reach_iter30", 32'(found), 32'd1);
    rst = 0;
    tick();
    rst = 1;
    #1 cmp("rst_mid", dut_vec(), RESET_VEC);
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      if (h_update) seen = 1;
      tick();
    end
    cmp("no_update_after_rst", 32'(seen), 32'd0);

`ifdef SHA_CTRL_ABORT_EN
    blk_valid = 1; blk_first = 1; blk_last = 1;
    tick();
    {blk_valid, blk_first, blk_last} = '0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (h_update) begin found = 1; break; end
      tick();
    end
    cmp("reach_update", 32'(found), 32'd1);
    abort = 1;
    #1 cmp("abort_gate", 32'(h_update), 32'd0);
    tick();
    abort = 0;
    cmp("abort_idle", 32'(busy), 32'd0);
    cmp("abort_cnt", 32'(blk_count), 32'd0);
    cmp("abort_no_dig", 32'(dig_valid), 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      blk_valid = ($urandom_range(0, 7) == 0);
      blk_first = 1'($urandom_range(0, 1));
      blk_last  = 1'($urandom_range(0, 1));
      dig_ready = ($urandom_range(0, 3) == 0);
      rst       = !($urandom_range(0, 499) == 0);
`ifdef SHA_CTRL_ABORT_EN
      abort     = ($urandom_range(0, 299) == 0);
`endif
      tick();
    end
    {blk_valid, blk_first, blk_last, dig_ready, abort} = '0;
    rst = 1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Sequencing controller for the SHA-256 core.
- Accepts 512-bit message blocks over a valid/ready handshake and drives `counter_iteration` (0..64) to the round datapath and the digest accumulator.
- Strobes message-schedule load, working-variable load, IV re-initialisation and chaining-value update.
- Presents a digest-valid handshake once the last block of a message has been folded into H0..H7.

Parameters:
- NUM_ROUNDS, 64, compression rounds per block; also the iteration value that triggers the digest add.
- CNT_W, 7, width of `counter_iteration`; must satisfy 2**CNT_W > NUM_ROUNDS.
- BLK_CNT_W, 16, width of the per-message block counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on posedge clk).
- blk_valid  in  1  upstream block (W0..W15) available.
- blk_first  in  1  qualifies blk_valid: block starts a new message.
- blk_last  in  1  qualifies blk_valid: block ends the message.
- blk_ready  out  1  controller can accept a block.
- ws_load  out  1  one-cycle strobe: message schedule captures block.
- wv_load  out  1  one-cycle strobe: a..h load from `wv_init_sel` source.
- wv_init_sel  out  1  1 = load a..h from the SHA-256 IV; 0 = load from current H0..H7.
- h_init  out  1  one-cycle strobe: digest accumulator reloads IV into H0..H7.
- round_en  out  1  round datapath advances this cycle.
- counter_iteration  out  CNT_W  round index to datapath and digest accumulator.
- h_update  out  1  one-cycle strobe, coincident with counter_iteration==NUM_ROUNDS.
- dig_valid  out  1  final digest stable on the accumulator output.
- dig_ready  in  1  downstream consumed the digest.
- busy  out  1  high in any state except IDLE.
- blk_count  out  BLK_CNT_W  blocks completed in the current message.

Behaviour:
- Reset (rst==0 at posedge) forces:
  - state IDLE, counter_iteration=0, blk_count=0, first_seen=0;
  - all strobes, dig_valid and busy = 0;
  - blk_ready=1 from the first cycle after reset.
- Reset mid-operation aborts the block; there is no partial digest and no h_update.

State machine (states IDLE, LOAD, ROUND, UPDATE, DONE):
- IDLE: blk_ready=1. On blk_valid&&blk_ready (cycle T):
  - latch first/last flags, go to LOAD;
  - if blk_first=1 or no message is open, assert h_init in cycle T+1 and clear blk_count;
  - blk_first=1 while a message is open abandons the open message silently.
- LOAD (T+1):
  - ws_load=1, wv_load=1, counter_iteration=0;
  - wv_init_sel=1 if the latched block is a first block, else 0.
- ROUND (T+2..T+65):
  - round_en=1; counter_iteration shows 0..63, incrementing each cycle;
  - exit to UPDATE after the cycle showing NUM_ROUNDS-1.
- UPDATE (T+66):
  - counter_iteration=NUM_ROUNDS, h_update=1 exactly once, round_en=0;
  - blk_count increments, saturating at all-ones;
  - next state: DONE if the block was last, else IDLE.
- DONE (from T+67):
  - dig_valid=1, blk_ready=0;
  - counter_iteration holds NUM_ROUNDS, but h_update stays 0;
  - on dig_ready=1: dig_valid drops the next cycle, go to IDLE, mark the message closed.
- dig_ready=1 in the same cycle dig_valid first rises is legal; DONE then lasts 1 cycle.

Throughput and timing:
- Accept-to-h_update latency is 66 cycles; minimum block period is 67 cycles.
- counter_iteration never exceeds NUM_ROUNDS and never wraps.
- blk_valid while blk_ready=0 is ignored; upstream must hold its data.
- blk_first && blk_last on the same block is a single-block message.

Optional Feature:
SHA_CTRL_ABORT_EN
- Defined:
  - adds input port `abort` (1 bit);
  - abort=1 in any state returns to IDLE next cycle, closes the message and clears counter_iteration and blk_count;
  - no h_update or dig_valid is issued;
  - abort in the UPDATE cycle still suppresses h_update, because the strobe is gated combinationally.
- Undefined: no port; an abandoned message ends only via blk_first or reset.

Decomposition:
- Package sha256_ctrl_pkg holds:
  - the state encoding (IDLE, LOAD, ROUND, UPDATE, DONE);
  - NUM_ROUNDS default 64 and ITER_DONE = 7'd64;
  - the IV constant vector, shared with the accumulator.
- One sub-module, sha256_round_counter:
  - clear/enable counter with terminal flag at NUM_ROUNDS-1;
  - holds at NUM_ROUNDS when loaded.

Test Plan:
- Reset then single block (first=1, last=1) accepted at T:
  - h_init and wv_init_sel=1 at T+1;
  - counter 0..63 at T+2..T+65, h_update at T+66 with counter=64;
  - dig_valid from T+67, blk_count=1.
- Two-block message:
  - block 2 accepted at T+67: wv_init_sel=0, no h_init;
  - exactly 2 h_update pulses; dig_valid only after the second; blk_count=2.
- dig_ready held low 10 cycles in DONE:
  - dig_valid stays 1, blk_ready stays 0, no extra h_update;
  - on dig_ready=1, dig_valid=0 next cycle and blk_ready=1.
- rst=0 at counter_iteration=30:
  - next cycle all outputs are at reset values;
  - no h_update is ever seen for that block.
- blk_first=1 arriving after a non-last block:
  - h_init reasserted, blk_count restarts at 0→1;
  - no dig_valid for the abandoned message.
- With SHA_CTRL_ABORT_EN, abort=1 in the UPDATE cycle:
  - h_update=0, state IDLE next cycle, blk_count=0.
